// File: rtl/fp_divide.sv
// FP32 sequential divider: radix-2 restoring mantissa division (26 iterations),
// round-to-nearest-even, flush-to-zero, valid/ready handshakes on both sides.
`timescale 1ns/1ps
module fp_divide (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a_operand,
  input  logic [31:0] b_operand,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        div_by_zero
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] DIV  = 2'd1;
  localparam logic [1:0] NORM = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]  state_q, state_d;
  logic        sign_q, sign_d;
  logic [7:0]  ea_q, ea_d;
  logic [7:0]  eb_q, eb_d;
  logic [23:0] mb_q, mb_d;
  logic [25:0] rem_q, rem_d;
  logic [25:0] quo_q, quo_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] result_q, result_d;
  logic        dbz_q, dbz_d;

  // Operand decode at the input port
  logic [7:0]  a_exp, b_exp;
  logic        a_zero, b_zero, in_sign;
  logic [23:0] a_man, b_man;

  always_comb begin
    a_exp   = a_operand[30:23];
    b_exp   = b_operand[30:23];
    a_zero  = (a_exp == 8'h00);
    b_zero  = (b_exp == 8'h00);
    a_man   = {!a_zero, a_operand[22:0]};
    b_man   = {!b_zero, b_operand[22:0]};
    in_sign = a_operand[31] ^ b_operand[31];
  end

  // One restoring-division step
  logic        rem_ge;
  logic [25:0] rem_sel;
  logic [25:0] rem_next;

  always_comb begin
    rem_ge   = (rem_q >= {2'b00, mb_q});
    rem_sel  = rem_ge ? (rem_q - {2'b00, mb_q}) : rem_q;
    rem_next = {rem_sel[24:0], 1'b0};
  end

  // Normalisation and rounding of the finished quotient
  logic               sticky, guard_bit, sticky_bit, round_up;
  logic [22:0]        m_pre, m_fin;
  logic [23:0]        m_sum;
  logic [9:0]         bias;
  logic signed [9:0]  e_pre, e_fin;
  logic [31:0]        norm_result;

  always_comb begin
    sticky = |rem_q;
    if (quo_q[25]) begin
      m_pre      = quo_q[24:2];
      guard_bit  = quo_q[1];
      sticky_bit = quo_q[0] | sticky;
      bias       = 10'd127;
    end else begin
      m_pre      = quo_q[23:1];
      guard_bit  = quo_q[0];
      sticky_bit = sticky;
      bias       = 10'd126;
    end
    e_pre    = $signed({2'b00, ea_q} - {2'b00, eb_q} + bias);
    round_up = guard_bit & (sticky_bit | m_pre[0]);
    m_sum    = {1'b0, m_pre} + {23'd0, round_up};
    if (m_sum[23]) begin
      m_fin = '0;
      e_fin = e_pre + 10'sd1;
    end else begin
      m_fin = m_sum[22:0];
      e_fin = e_pre;
    end
    if (e_fin >= 10'sd255) begin
      norm_result = {sign_q, 8'hFF, 23'd0};
    end else if (e_fin <= 10'sd0) begin
      norm_result = {sign_q, 31'd0};
    end else begin
      norm_result = {sign_q, e_fin[7:0], m_fin};
    end
  end

  always_comb begin
    state_d  = state_q;
    sign_d   = sign_q;
    ea_d     = ea_q;
    eb_d     = eb_q;
    mb_d     = mb_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    dbz_d    = dbz_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          sign_d = in_sign;
          ea_d   = a_exp;
          eb_d   = b_exp;
          mb_d   = b_man;
          rem_d  = {2'b00, a_man};
          quo_d  = '0;
          cnt_d  = '0;
          // Special cases resolve here and skip the iteration entirely
          if (a_exp == 8'hFF || b_exp == 8'hFF) begin
            result_d = '0;
            dbz_d    = 1'b0;
            state_d  = DONE;
          end else if (a_zero && b_zero) begin
            result_d = '0;
            dbz_d    = 1'b0;
            state_d  = DONE;
          end else if (b_zero) begin
            result_d = {in_sign, 8'hFF, 23'd0};
            dbz_d    = 1'b1;
            state_d  = DONE;
          end else if (a_zero) begin
            result_d = {in_sign, 31'd0};
            dbz_d    = 1'b0;
            state_d  = DONE;
          end else begin
            state_d = DIV;
          end
        end
      end
      DIV: begin
        rem_d = rem_next;
        quo_d = {quo_q[24:0], rem_ge};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd25) begin
          state_d = NORM;
        end
      end
      NORM: begin
        result_d = norm_result;
        dbz_d    = 1'b0;
        state_d  = DONE;
      end
      default: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      sign_q   <= 1'b0;
      ea_q     <= '0;
      eb_q     <= '0;
      mb_q     <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sign_q   <= sign_d;
      ea_q     <= ea_d;
      eb_q     <= eb_d;
      mb_q     <= mb_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      dbz_q    <= dbz_d;
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign result      = result_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_fp_divide.sv
// Directed scoreboard bench for fp_divide: normal, special, range, back-pressure
// and mid-operation reset scenarios.
`timescale 1ns/1ps
module tb_fp_divide;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a_operand;
  logic [31:0] b_operand;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        div_by_zero;

  fp_divide dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a_operand   (a_operand),
    .b_operand   (b_operand),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] res;
    logic        dbz;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad   = 0;
  logic [31:0] last_res;
  logic        last_dbz;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one operand pair and push its expected outcome; returns after the accept edge.
  task automatic issue(input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] res, input logic dbz);
    exp_t e;
    int   waited;
    waited = 0;
    while (!in_ready && waited < 100) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!in_ready) chk("in_ready_timeout", {31'd0, in_ready}, 32'd1);
    a_operand = a;
    b_operand = b;
    in_valid  = 1'b1;
    e.res = res;
    e.dbz = dbz;
    sb.push_back(e);
    @(posedge clk); #1;
    in_valid  = 1'b0;
    a_operand = $urandom;
    b_operand = $urandom;
  endtask

  // Called 1 time unit after the accept edge; counts edges until out_valid.
  task automatic wait_out(input string tag, input int lat);
    exp_t e;
    int   n;
    n = 1;
    while (!out_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_lat"}, 32'(n), 32'(lat));
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk({tag, "_res"}, result, e.res);
      chk({tag, "_dbz"}, {31'd0, div_by_zero}, {31'd0, e.dbz});
      last_res = e.res;
      last_dbz = e.dbz;
    end
  endtask

  // Handoff with out_ready already high.
  task automatic handoff(input string tag);
    @(posedge clk); #1;
    chk({tag, "_ov_drop"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_ir_rise"}, {31'd0, in_ready}, 32'd1);
    chk({tag, "_res_hold"}, result, last_res);
  endtask

  task automatic run(input string tag, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] res, input logic dbz, input int lat);
    issue(a, b, res, dbz);
    wait_out(tag, lat);
    handoff(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a_operand = '0;
    b_operand = '0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_in_ready",  {31'd0, in_ready},    32'd1);
    chk("rst_out_valid", {31'd0, out_valid},   32'd0);
    chk("rst_result",    result,               32'd0);
    chk("rst_dbz",       {31'd0, div_by_zero}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run("six_div_two", 32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, 28);
    run("one_third",   32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 1'b0, 28);
    run("pos_dbz",     32'h3F800000, 32'h00000000, 32'h7F800000, 1'b1, 1);
    run("neg_dbz",     32'hBF800000, 32'h00000000, 32'hFF800000, 1'b1, 1);
    run("zero_zero",   32'h00000000, 32'h00000000, 32'h00000000, 1'b0, 1);
    run("inf_a",       32'h7F800000, 32'h3F800000, 32'h00000000, 1'b0, 1);
    run("neg_zero_a",  32'h80000000, 32'h3F800000, 32'h80000000, 1'b0, 1);
    run("overflow",    32'h7F000000, 32'h00800000, 32'h7F800000, 1'b0, 28);
    run("underflow",   32'h00800000, 32'h43000000, 32'h00000000, 1'b0, 28);
    run("seven_half",  32'h40E00000, 32'h3F000000, 32'h41600000, 1'b0, 28);

    // Back-pressure: result must hold and a stray in_valid must be ignored
    out_ready = 1'b0;
    issue(32'h40C00000, 32'h40000000, 32'h40400000, 1'b0);
    wait_out("bp", 28);
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin
        a_operand = 32'h3F800000;
        b_operand = 32'h00000000;
        in_valid  = 1'b1;
      end else begin
        in_valid  = 1'b0;
      end
      @(posedge clk); #1;
      chk("bp_res_stable", result, last_res);
      chk("bp_dbz_stable", {31'd0, div_by_zero}, {31'd0, last_dbz});
      chk("bp_in_ready",   {31'd0, in_ready}, 32'd0);
      chk("bp_out_valid",  {31'd0, out_valid}, 32'd1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    handoff("bp");
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("bp_no_ghost", {31'd0, out_valid}, 32'd0);
    end

    // Reset mid-operation: abort inside DIV, then a fresh divide
    issue(32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 1'b0);
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", {31'd0, out_valid},   32'd0);
    chk("mid_rst_in_ready",  {31'd0, in_ready},    32'd1);
    chk("mid_rst_result",    result,               32'd0);
    chk("mid_rst_dbz",       {31'd0, div_by_zero}, 32'd0);
    void'(sb.pop_back());
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      chk("mid_rst_no_output", {31'd0, out_valid}, 32'd0);
      if (i == 2) break;
    end
    run("neg_six_div_two", 32'hC0C00000, 32'h40000000, 32'hC0400000, 1'b0, 28);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
